// File: rtl/bfm_apb_slave_mem_pkg.sv
// Shared definitions for the APB slave BFMs: bus widths and the
// transfer-phase encoding used by the slave FSM and its protocol checker.
package bfm_apb_slave_mem_pkg;

  localparam int APB_DW     = 32;
  localparam int APB_DEC_AW = 24;
  localparam int CNT_W      = 4;
  localparam int XCNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2
  } apb_state_e;

  // Even parity over a bus word, used by benches that sideband-check data.
  function automatic logic word_parity(input logic [APB_DW-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/bfm_apb_slave_mem_if.sv
// APB3 bus bundle between the bridge BFM (master) and one slave BFM.
interface bfm_apb_slave_mem_if;
  import bfm_apb_slave_mem_pkg::*;

  logic              PSEL;
  logic [APB_DW-1:0] PADDR;
  logic              PWRITE;
  logic              PENABLE;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/bfm_apb_protchk.sv
// APB protocol checker: captures the setup-phase address/direction/data and
// raises a sticky PROTERR on missing setup, unstable access signals or abandon.
module bfm_apb_protchk
  import bfm_apb_slave_mem_pkg::*;
(
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_DW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  input  apb_state_e        state,
  output logic [APB_DW-1:0] a_addr,
  output logic              a_wr,
  output logic [APB_DW-1:0] a_data,
  output logic              viol,
  output logic              proterr
);

  logic [APB_DW-1:0] a_addr_r;
  logic [APB_DW-1:0] a_data_r;
  logic              a_wr_r;
  logic              proterr_r;
  logic              active_s;
  logic              mismatch_s;
  logic              viol_s;
  logic              err_s;

  // Capture the transfer attributes presented in the setup phase.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      a_addr_r <= {APB_DW{1'b0}};
      a_data_r <= {APB_DW{1'b0}};
      a_wr_r   <= 1'b0;
    end else if (psel && !penable) begin
      a_addr_r <= paddr;
      a_data_r <= pwdata;
      a_wr_r   <= pwrite;
    end
  end

  // Classify the current cycle against the captured setup attributes.
  always_comb begin
    active_s   = (state != ST_IDLE);
    mismatch_s = (paddr != a_addr_r) || (pwrite != a_wr_r) ||
                 (a_wr_r && (pwdata != a_data_r));
    viol_s     = psel && penable && active_s && mismatch_s;
    err_s      = (psel && penable && !active_s) || viol_s || (!psel && active_s);
  end

  // Sticky violation flag, cleared only by reset.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      proterr_r <= 1'b0;
    end else begin
      proterr_r <= proterr_r | err_s;
    end
  end

  assign a_addr  = a_addr_r;
  assign a_wr    = a_wr_r;
  assign a_data  = a_data_r;
  assign viol    = viol_s;
  assign proterr = proterr_r;

endmodule

// File: rtl/bfm_apb_slave_mem.sv
// APB3 slave memory BFM: word RAM with programmable wait states, transfer counter
// and protocol checking. Define BFM_APBSLV_ERR_EN to answer out-of-range with PSLVERR.
module bfm_apb_slave_mem
  import bfm_apb_slave_mem_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int TPD         = 1
) (
  input  logic                HCLK,
  input  logic                HRESETN,
  bfm_apb_slave_mem_if.slave  apb,
  output logic                PROTERR,
  output logic [XCNT_W-1:0]   XFER_CNT
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  // Output delay is meaningless in synthesizable logic; kept so instantiations stay compatible.
  localparam int TPD_UNUSED = TPD;

  apb_state_e        state_r;
  apb_state_e        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [XCNT_W-1:0] xfer_cnt_r;
  logic [APB_DW-1:0] mem_r [MEM_DEPTH];

  logic [APB_DW-1:0] a_addr_s;
  logic [APB_DW-1:0] a_data_s;
  logic              a_wr_s;
  logic              viol_s;
  logic              proterr_s;
  logic [AW-1:0]     a_word_s;
  logic              access_s;
  logic              pready_s;
  logic              oor_s;
  logic              wr_en_s;
  logic [APB_DW-1:0] prdata_s;
  logic              unused_s;

  bfm_apb_protchk u_protchk (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .psel    (apb.PSEL),
    .penable (apb.PENABLE),
    .pwrite  (apb.PWRITE),
    .paddr   (apb.PADDR),
    .pwdata  (apb.PWDATA),
    .state   (state_r),
    .a_addr  (a_addr_s),
    .a_wr    (a_wr_s),
    .a_data  (a_data_s),
    .viol    (viol_s),
    .proterr (proterr_s)
  );

  assign a_word_s = a_addr_s[AW+1:2];
  assign access_s = apb.PSEL && apb.PENABLE && (state_r != ST_IDLE);
  assign pready_s = access_s && (cnt_r == {CNT_W{1'b0}});
  assign unused_s = ^a_addr_s;

`ifdef BFM_APBSLV_ERR_EN
  localparam logic [APB_DEC_AW-1:0] OOR_LIMIT = APB_DEC_AW'(4 * MEM_DEPTH);
  assign oor_s       = (a_addr_s[APB_DEC_AW-1:0] >= OOR_LIMIT);
  assign apb.PSLVERR = pready_s && oor_s;
`else
  assign oor_s       = 1'b0;
  assign apb.PSLVERR = 1'b0;
`endif

  // Phase and wait-counter state register.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next phase from the bus signals seen at this edge.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (!apb.PSEL) begin
      state_nxt_s = ST_IDLE;
    end else if (!apb.PENABLE) begin
      state_nxt_s = ST_SETUP;
      cnt_nxt_s   = WAIT_INIT;
    end else if (!pready_s) begin
      state_nxt_s = ST_WAIT;
      cnt_nxt_s   = cnt_r - 4'd1;
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // Commit qualification and read-data gating.
  always_comb begin
    wr_en_s  = pready_s && a_wr_s && !viol_s && !oor_s;
    prdata_s = {APB_DW{1'b0}};
    if (access_s && !a_wr_s && !oor_s) begin
      prdata_s = mem_r[a_word_s];
    end else begin
      prdata_s = {APB_DW{1'b0}};
    end
  end

  // Word RAM, cleared on reset so a reset discards any pending or past write.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= {APB_DW{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[a_word_s] <= a_data_s;
    end
  end

  // Completed-transfer counter; error responses count too.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      xfer_cnt_r <= {XCNT_W{1'b0}};
    end else if (pready_s) begin
      xfer_cnt_r <= xfer_cnt_r + 16'd1;
    end
  end

  assign apb.PRDATA = prdata_s;
  assign apb.PREADY = pready_s;
  assign PROTERR    = proterr_s;
  assign XFER_CNT   = xfer_cnt_r;

endmodule

// File: tb/tb_bfm_apb_slave_mem.sv
// Bench for bfm_apb_slave_mem: one zero-wait and one three-wait instance,
// transfers scored through an expectation queue.
module tb_bfm_apb_slave_mem;

  logic HCLK;
  logic HRESETN;

  logic        psel_d    [2];
  logic        penable_d [2];
  logic        pwrite_d  [2];
  logic [31:0] paddr_d   [2];
  logic [31:0] pwdata_d  [2];
  logic        perr0, perr3;
  logic [15:0] cnt0, cnt3;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;
  exp_t sb_q[$];

  bfm_apb_slave_mem_if if0();
  bfm_apb_slave_mem_if if3();

  assign if0.PSEL    = psel_d[0];
  assign if0.PENABLE = penable_d[0];
  assign if0.PWRITE  = pwrite_d[0];
  assign if0.PADDR   = paddr_d[0];
  assign if0.PWDATA  = pwdata_d[0];
  assign if3.PSEL    = psel_d[1];
  assign if3.PENABLE = penable_d[1];
  assign if3.PWRITE  = pwrite_d[1];
  assign if3.PADDR   = paddr_d[1];
  assign if3.PWDATA  = pwdata_d[1];

  bfm_apb_slave_mem #(.MEM_DEPTH(256), .WAIT_CYCLES(0), .TPD(1)) u_dut0 (
    .HCLK(HCLK), .HRESETN(HRESETN), .apb(if0), .PROTERR(perr0), .XFER_CNT(cnt0)
  );

  bfm_apb_slave_mem #(.MEM_DEPTH(256), .WAIT_CYCLES(3), .TPD(1)) u_dut3 (
    .HCLK(HCLK), .HRESETN(HRESETN), .apb(if3), .PROTERR(perr3), .XFER_CNT(cnt3)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic get_ready(input int u);
    return (u == 0) ? if0.PREADY : if3.PREADY;
  endfunction

  function automatic logic [31:0] get_rdata(input int u);
    return (u == 0) ? if0.PRDATA : if3.PRDATA;
  endfunction

  function automatic logic get_err(input int u);
    return (u == 0) ? if0.PSLVERR : if3.PSLVERR;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle(input int u);
    psel_d[u]    = 1'b0;
    penable_d[u] = 1'b0;
    pwrite_d[u]  = 1'b0;
    paddr_d[u]   = 32'h0;
    pwdata_d[u]  = 32'h0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the completing edge, bus released.
  task automatic apb_xfer(input int u, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat, input string tag);
    exp_t e;
    exp_t got;
    int   lat;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = 8'(exp_lat);
    sb_q.push_back(e);
    psel_d[u]    = 1'b1;
    penable_d[u] = 1'b0;
    pwrite_d[u]  = wr;
    paddr_d[u]   = addr;
    pwdata_d[u]  = wdata;
    @(posedge HCLK); #1;
    penable_d[u] = 1'b1;
    lat = 2;
    while (1) begin
      @(negedge HCLK);
      if (get_ready(u)) break;
      if (lat >= 40) begin
        $display("FAIL %s_timeout: no PREADY after %0d cycles", tag, lat);
        n_miss++;
        break;
      end
      @(posedge HCLK); #1;
      lat++;
    end
    got = sb_q.pop_front();
    check_val({tag, "_lat"},   32'(lat),       32'(got.lat));
    check_val({tag, "_rdata"}, get_rdata(u),   got.rdata);
    check_val({tag, "_err"},   32'(get_err(u)), 32'(got.err));
    @(posedge HCLK); #1;
    bus_idle(u);
  endtask

  initial begin
    logic [31:0] exp_w0;
    logic [31:0] exp_a400;
    logic        exp_oor;
    bus_idle(0);
    bus_idle(1);
    HRESETN = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check_val("rst_prdata0", if0.PRDATA, 32'h0);
    check_val("rst_pready0", 32'(if0.PREADY), 32'h0);
    check_val("rst_cnt0",    32'(cnt0), 32'h0);
    check_val("rst_proterr0", 32'(perr0), 32'h0);
    HRESETN = 1'b1;
    @(posedge HCLK); #1;

    // zero-wait write then read
    apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "t1_wr");
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "t1_rd");
    check_val("t1_cnt", 32'(cnt0), 32'd2);

    // three wait states on a fresh word
    apb_xfer(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5, "t2_rd");
    check_val("t2_cnt", 32'(cnt3), 32'd1);

    // back-to-back: read directly follows the write with no idle cycle
    psel_d[0] = 1'b1;
    apb_xfer(0, 1'b1, 32'h4, 32'h1234, 32'h0, 1'b0, 2, "t3_wr");
    apb_xfer(0, 1'b0, 32'h4, 32'h0, 32'h00001234, 1'b0, 2, "t3_rd");
    check_val("t3_proterr", 32'(perr0), 32'h0);
    check_val("t3_cnt", 32'(cnt0), 32'd4);

    // address one past the end of a 256-word memory
`ifdef BFM_APBSLV_ERR_EN
    exp_oor  = 1'b1;
    exp_w0   = 32'h0;
    exp_a400 = 32'h0;
`else
    exp_oor  = 1'b0;
    exp_w0   = 32'hA5A5A5A5;
    exp_a400 = 32'hA5A5A5A5;
`endif
    apb_xfer(0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, exp_oor, 2, "t4_wr");
    apb_xfer(0, 1'b0, 32'h0, 32'h0, exp_w0, 1'b0, 2, "t4_rd0");
    apb_xfer(0, 1'b0, 32'h400, 32'h0, exp_a400, exp_oor, 2, "t4_rd400");
    check_val("t4_cnt", 32'(cnt0), 32'd7);
    check_val("t4_proterr", 32'(perr0), 32'h0);

    // access phase without a setup phase
    psel_d[0]    = 1'b1;
    penable_d[0] = 1'b1;
    paddr_d[0]   = 32'h20;
    @(negedge HCLK);
    check_val("t5_pready", 32'(if0.PREADY), 32'h0);
    check_val("t5_prdata", if0.PRDATA, 32'h0);
    @(posedge HCLK); #1;
    check_val("t5_proterr_set", 32'(perr0), 32'h1);
    bus_idle(0);
    repeat (3) @(posedge HCLK);
    #1;
    check_val("t5_proterr_sticky", 32'(perr0), 32'h1);
    check_val("t5_cnt", 32'(cnt0), 32'd7);

    // reset while a write sits in wait states
    psel_d[1]    = 1'b1;
    pwrite_d[1]  = 1'b1;
    paddr_d[1]   = 32'h8;
    pwdata_d[1]  = 32'h55AA55AA;
    @(posedge HCLK); #1;
    penable_d[1] = 1'b1;
    @(posedge HCLK); #1;
    check_val("t6_wait_pready", 32'(if3.PREADY), 32'h0);
    #1;
    HRESETN = 1'b0;
    #1;
    check_val("t6_rst_cnt3", 32'(cnt3), 32'h0);
    check_val("t6_rst_cnt0", 32'(cnt0), 32'h0);
    check_val("t6_rst_proterr0", 32'(perr0), 32'h0);
    check_val("t6_rst_pready3", 32'(if3.PREADY), 32'h0);
    bus_idle(1);
    @(posedge HCLK); #3;
    HRESETN = 1'b1;
    @(posedge HCLK); #1;
    apb_xfer(1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 5, "t6_rd8");
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 2, "t6_rd10");
    check_val("t6_cnt3", 32'(cnt3), 32'd1);
    check_val("t6_proterr3", 32'(perr3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
